// File: rtl/uart_cmd_decoder.sv
// Command decoder behind uart_rx: validates Hamming(7,4) frames, drives out_en, replies ACK/NACK.
// Optional single-bit correction enabled by defining HAMMING_CORRECT_EN.
module uart_cmd_decoder #(
    parameter logic [7:0]  ACK_BYTE   = 8'h3C,
    parameter logic [7:0]  NACK_BYTE  = 8'hC3,
    parameter int unsigned TX_TIMEOUT = 1000,
    parameter logic [3:0]  CMD_ON     = 4'h6,
    parameter logic [3:0]  CMD_OFF    = 4'hD
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_done_i,
    input  logic       parity_error_i,
    input  logic       tx_busy_i,
    output logic [7:0] tx_data_o,
    output logic       start_tx_o,
    output logic       out_en_o,
    output logic       cmd_strobe_o,
    output logic [7:0] err_count_o
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StDecode   = 2'd1;
    localparam logic [1:0] StSendReq  = 2'd2;
    localparam logic [1:0] StSendWait = 2'd3;

    localparam int unsigned TimerW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    logic [1:0]        state_q, state_d;
    logic [7:0]        frame_q, frame_d;
    logic              perr_q, perr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              start_tx_q, start_tx_d;
    logic              out_en_q, out_en_d;
    logic              strobe_q, strobe_d;
    logic [7:0]        err_q, err_d;
    logic [TimerW-1:0] timer_q, timer_d;

    logic [6:0] code, code_fix;
    logic [2:0] syn;
    logic [3:0] nibble;
    logic       unrecov, is_on, is_off, accept;
    logic       overrun, reject, timeout;
    logic [8:0] err_sum;

    // Syndrome and nibble extraction from the registered frame
    always_comb begin
        code = frame_q[6:0];
        syn  = {code[3] ^ code[4] ^ code[5] ^ code[6],
                code[1] ^ code[2] ^ code[5] ^ code[6],
                code[0] ^ code[2] ^ code[4] ^ code[6]};
`ifdef HAMMING_CORRECT_EN
        for (int i = 0; i < 7; i++) begin
            code_fix[i] = code[i] ^ (syn == 3'(i + 1));
        end
        unrecov = 1'b0;
`else
        code_fix = code;
        unrecov  = (syn != 3'd0);
`endif
        nibble = {code_fix[6], code_fix[5], code_fix[4], code_fix[2]};
        is_on  = (nibble == CMD_ON);
        is_off = (nibble == CMD_OFF);
        accept = !perr_q && frame_q[7] && !unrecov && (is_on || is_off);
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        perr_d     = perr_q;
        tx_data_d  = tx_data_q;
        start_tx_d = start_tx_q;
        out_en_d   = out_en_q;
        strobe_d   = 1'b0;
        timer_d    = timer_q;
        reject     = 1'b0;
        timeout    = 1'b0;
        overrun    = rx_done_i && (state_q != StIdle);

        case (state_q)
            StIdle: begin
                if (rx_done_i) begin
                    frame_d = rx_data_i;
                    perr_d  = parity_error_i;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (accept) begin
                    out_en_d  = is_on;
                    strobe_d  = 1'b1;
                    tx_data_d = ACK_BYTE;
                end else begin
                    tx_data_d = NACK_BYTE;
                    reject    = 1'b1;
                end
                start_tx_d = 1'b1;
                timer_d    = '0;
                state_d    = StSendReq;
            end
            StSendReq: begin
                if (tx_busy_i) begin
                    start_tx_d = 1'b0;
                    state_d    = StSendWait;
                end else if (timer_q == TimerW'(TX_TIMEOUT - 1)) begin
                    start_tx_d = 1'b0;
                    timeout    = 1'b1;
                    state_d    = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StSendWait: begin
                start_tx_d = 1'b0;
                if (!tx_busy_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Overrun can coincide with a reject or timeout, giving +2
        err_sum = {1'b0, err_q} + {8'd0, overrun} + {8'd0, reject | timeout};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            frame_q    <= '0;
            perr_q     <= 1'b0;
            tx_data_q  <= '0;
            start_tx_q <= 1'b0;
            out_en_q   <= 1'b0;
            strobe_q   <= 1'b0;
            err_q      <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            perr_q     <= perr_d;
            tx_data_q  <= tx_data_d;
            start_tx_q <= start_tx_d;
            out_en_q   <= out_en_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
        end
    end

    assign tx_data_o    = tx_data_q;
    assign start_tx_o   = start_tx_q;
    assign out_en_o     = out_en_q;
    assign cmd_strobe_o = strobe_q;
    assign err_count_o  = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: a uart_tx model pops expected reply bytes
// from a scoreboard queue filled when each frame is driven.
module tb_uart_cmd_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       parity_error;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       start_tx;
    logic       out_en;
    logic       cmd_strobe;
    logic [7:0] err_count;

    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         tx_count = 0;
    bit         model_en = 1'b1;

    uart_cmd_decoder dut (
        .clk_i          (clk),
        .reset_ni       (rst_n),
        .rx_data_i      (rx_data),
        .rx_done_i      (rx_done),
        .parity_error_i (parity_error),
        .tx_busy_i      (tx_busy),
        .tx_data_o      (tx_data),
        .start_tx_o     (start_tx),
        .out_en_o       (out_en),
        .cmd_strobe_o   (cmd_strobe),
        .err_count_o    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // uart_tx model: answers start_tx after a short delay, checks the byte against the scoreboard
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_en && start_tx && !tx_busy) begin
                repeat (3) @(negedge clk);
                check_eq("start_tx_held", start_tx, 1);
                check_eq("tx_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check_eq("tx_data", tx_data, exp_q.pop_front());
                tx_count++;
                tx_busy = 1'b1;
                repeat (10) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic pe);
        rx_data      = d;
        parity_error = pe;
        rx_done      = 1'b1;
        @(negedge clk);
        rx_done      = 1'b0;
        parity_error = 1'b0;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy || start_tx) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check_eq("settle_bound", n, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        int tx0;
        rx_data      = 8'h00;
        rx_done      = 1'b0;
        parity_error = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_start_tx", start_tx, 0);
        check_eq("rst_out_en", out_en, 0);
        check_eq("rst_cmd_strobe", cmd_strobe, 0);
        check_eq("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ON command with cycle-accurate latency
        exp_q.push_back(8'h3C);
        send(8'hB3, 1'b0);
        check_eq("lat1_out_en", out_en, 0);
        check_eq("lat1_start_tx", start_tx, 0);
        @(negedge clk);
        check_eq("lat2_out_en", out_en, 1);
        check_eq("lat2_cmd_strobe", cmd_strobe, 1);
        check_eq("lat2_start_tx", start_tx, 1);
        check_eq("lat2_tx_data", tx_data, 8'h3C);
        @(negedge clk);
        check_eq("lat3_cmd_strobe", cmd_strobe, 0);
        settle();
        check_eq("on_out_en", out_en, 1);
        exp_q.push_back(8'h3C);
        send(8'hE6, 1'b0);
        settle();
        check_eq("off_out_en", out_en, 0);
        check_eq("off_err_count", err_count, 0);

        // Single-bit error at position 3
        do_reset();
`ifdef HAMMING_CORRECT_EN
        exp_q.push_back(8'h3C);
        send(8'hB7, 1'b0);
        settle();
        check_eq("corr_out_en", out_en, 1);
        check_eq("corr_err_count", err_count, 0);
`else
        exp_q.push_back(8'hC3);
        send(8'hB7, 1'b0);
        settle();
        check_eq("corr_out_en", out_en, 0);
        check_eq("corr_err_count", err_count, 1);
`endif

        // Marker clear, parity error, valid codeword of a non-command nibble
        do_reset();
        exp_q.push_back(8'h3C);
        send(8'hB3, 1'b0);
        settle();
        exp_q.push_back(8'hC3);
        send(8'h33, 1'b0);
        settle();
        exp_q.push_back(8'hC3);
        send(8'hB3, 1'b1);
        settle();
        exp_q.push_back(8'hC3);
        send(8'h80, 1'b0);
        settle();
        check_eq("rej_out_en", out_en, 1);
        check_eq("rej_err_count", err_count, 3);

        // Overrun during SEND_WAIT
        do_reset();
        tx0 = tx_count;
        exp_q.push_back(8'h3C);
        send(8'hB3, 1'b0);
        n = 0;
        while (!tx_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("ovr_busy_seen", tx_busy, 1);
        @(negedge clk);
        send(8'hE6, 1'b0);
        settle();
        check_eq("ovr_err_count", err_count, 1);
        check_eq("ovr_out_en", out_en, 1);
        check_eq("ovr_tx_count", tx_count - tx0, 1);

        // TX timeout with tx_busy tied low
        do_reset();
        model_en = 1'b0;
        send(8'hB3, 1'b0);
        n   = 0;
        cnt = 0;
        while (n < 1200) begin
            @(negedge clk);
            n++;
            if (start_tx) cnt++;
            else if (cnt > 0) break;
        end
        check_eq("to_start_cycles", cnt, 1000);
        check_eq("to_start_tx", start_tx, 0);
        check_eq("to_err_count", err_count, 1);
        check_eq("to_out_en", out_en, 1);
        model_en = 1'b1;
        exp_q.push_back(8'h3C);
        send(8'hE6, 1'b0);
        settle();
        check_eq("to_idle_out_en", out_en, 0);
        check_eq("to_idle_err", err_count, 1);
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(8'hC3);
            send(8'h33, 1'b0);
            settle();
        end
        check_eq("sat_err_count", err_count, 8'hFF);

        // Asynchronous reset while start_tx is held
        do_reset();
        exp_q.push_back(8'hC3);
        send(8'h33, 1'b0);
        settle();
        model_en = 1'b0;
        send(8'hB3, 1'b0);
        @(negedge clk);
        check_eq("pre_rst_start_tx", start_tx, 1);
        check_eq("pre_rst_out_en", out_en, 1);
        check_eq("pre_rst_err", err_count, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_start_tx", start_tx, 0);
        check_eq("async_out_en", out_en, 0);
        check_eq("async_err", err_count, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        @(negedge clk);
        model_en = 1'b1;
        exp_q.push_back(8'h3C);
        send(8'hE6, 1'b0);
        settle();
        check_eq("post_rst_out_en", out_en, 0);
        check_eq("post_rst_err", err_count, 0);
        check_eq("post_rst_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Downstream consumer of uart_rx on each FPGA_modulo board: takes received bytes, validates and Hamming(7,4)-decodes command frames, and drives the module output-enable.
- Answers every accepted frame with an ACK or NACK byte through uart_tx, using the start_tx/tx_busy handshake.
- Keeps a saturating error counter for link diagnostics.

Parameters:
- ACK_BYTE, 8'h3C, byte sent for an accepted command.
- NACK_BYTE, 8'hC3, byte sent for a rejected frame.
- TX_TIMEOUT, 1000, maximum cycles in SEND_REQ waiting for tx_busy to rise.
- CMD_ON, 4'h6, decoded nibble that sets out_en.
- CMD_OFF, 4'hD, decoded nibble that clears out_en.

Ports:
- clk  in  1  system clock (24 MHz from HFOSC).
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  data_received from uart_rx.
- rx_done  in  1  one-cycle strobe from uart_rx; rx_data valid.
- parity_error  in  1  uart_rx parity flag, valid with rx_done.
- tx_busy  in  1  busy flag from uart_tx.
- tx_data  out  8  byte to transmit, drives data_to_tx.
- start_tx  out  1  transmit request.
- out_en  out  1  module output enable; 1 = SPWM outputs enabled.
- cmd_strobe  out  1  one-cycle pulse when out_en is updated by a valid command.
- err_count  out  8  saturating count of rejected frames, overruns and TX timeouts.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: tx_data=0, start_tx=0, out_en=0, cmd_strobe=0, err_count=0.
  - State: IDLE.
  - A reset mid-transmission drops start_tx immediately and abandons the reply.
- Frame format:
  - bit7 is the command marker and must be 1.
  - bits[6:0] hold a Hamming codeword, bit0 = position 1 ... bit6 = position 7.
  - Position map: p1, p2, d1, p3, d2, d3, d4. Decoded nibble = {d4, d3, d2, d1}.
- Syndrome: s1 = xor(pos 1,3,5,7); s2 = xor(pos 2,3,6,7); s3 = xor(pos 4,5,6,7); S = {s3,s2,s1}.
- States:
  - IDLE: on rx_done=1, register rx_data and parity_error, go to DECODE.
  - DECODE (1 cycle): evaluate the registered frame.
    - Reject if parity_error=1, bit7=0, the syndrome is unrecoverable, or the nibble is neither CMD_ON nor CMD_OFF. On reject: tx_data<=NACK_BYTE and err_count+1.
    - Otherwise accept: out_en<=1 for CMD_ON or 0 for CMD_OFF, cmd_strobe<=1 for one cycle, tx_data<=ACK_BYTE.
    - Always proceed to SEND_REQ.
  - SEND_REQ: hold start_tx=1 until tx_busy=1 is sampled, then go to SEND_WAIT. If TX_TIMEOUT cycles elapse first: start_tx<=0, err_count+1, go to IDLE.
  - SEND_WAIT: start_tx=0; when tx_busy=0, go to IDLE.
- Latency: rx_done high in cycle N puts DECODE in N+1. out_en, cmd_strobe and tx_data are visible in N+2, and start_tx rises in N+2.
- A repeated command re-asserts the same out_en value; cmd_strobe still pulses and ACK is still sent.
- rx_done outside IDLE: the byte is dropped (overrun), err_count+1, out_en unchanged.
- err_count saturates at 8'hFF; no wrap.
- Simultaneous events in one cycle: when an overrun and a reject/timeout coincide, err_count increments by 2, saturating.
- tx_data stays stable from DECODE until the return to IDLE.

Optional Feature:
- Macro: HAMMING_CORRECT_EN.
- Defined: S≠0 flips the codeword bit at position S before extracting the nibble (single-bit correction). The corrected frame is treated as valid if its nibble matches a command.
- Undefined: any S≠0 rejects the frame as unrecoverable (NACK, err_count+1).
- Encodings: CMD_ON encodes to 0xB3 and CMD_OFF to 0xE6, regardless of the macro.

Test Plan:
- Reset release, rx 0xB3 -> out_en 0->1 two cycles after rx_done, cmd_strobe single pulse, start_tx held until tx_busy, tx_data=0x3C; then rx 0xE6 -> out_en=0, ACK 0x3C.
- rx 0xB7 (0xB3 with position 3 flipped):
  - with HAMMING_CORRECT_EN: out_en=1, ACK, err_count=0.
  - without it: out_en unchanged, NACK 0xC3, err_count=1.
- rx 0x33 (marker clear), 0xB3 with parity_error=1, and a valid codeword of nibble 4'h0 -> each gives NACK 0xC3, out_en unchanged, err_count=3.
- rx 0xB3, second rx_done arriving during SEND_WAIT -> second byte ignored, err_count=1, exactly one ACK sent.
- tx_busy tied 0, rx 0xB3 -> out_en=1, start_tx drops after 1000 cycles, err_count=1, back to IDLE; 300 rejected frames -> err_count holds 0xFF.
- reset asserted while start_tx=1 -> start_tx, out_en and err_count go to 0 without waiting for a clock edge; next rx 0xE6 is processed normally.
